// File: rtl/mac16_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac16_seq_pkg
//   Shared types and constants for the SB_MAC16 dot-product sequencer.
//   - state_e     : sequencer FSM states
//   - MAC_OW      : MAC16 output (accumulator) width
//   - MAC_IW      : MAC16 A/B operand width
//   - ACC_LAT_DEF : default edges from operand accept to accumulator load
// -----------------------------------------------------------------------------
package mac16_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

  localparam int MAC_OW      = 32;
  localparam int MAC_IW      = 16;
  localparam int ACC_LAT_DEF = 2;

endpackage

// File: rtl/mac16_vld_pipe.sv
// -----------------------------------------------------------------------------
// mac16_vld_pipe
//   Valid shift register that tracks operand pairs travelling through the
//   MAC16 input/pipeline registers. Bit 0 captures the accept strobe; the
//   last bit marks the cycle in which the product reaches the accumulator.
// Ports
//   CLK    in  clock
//   RST    in  asynchronous active-high reset (clears all stages)
//   in_vld in  operand pair accepted this cycle
//   tail   out product valid at the accumulator input (last stage)
//   empty  out no product in flight
// -----------------------------------------------------------------------------
module mac16_vld_pipe #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic in_vld,
  output logic tail,
  output logic empty
);

  logic [DEPTH-1:0] vld_sr_q, vld_sr_d;

  // Shift form chosen so DEPTH=1 needs no zero-width slice.
  always_comb begin
    vld_sr_d = (vld_sr_q << 1) | DEPTH'(in_vld);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_sr_q <= '0;
    else     vld_sr_q <= vld_sr_d;
  end

  assign tail  = vld_sr_q[DEPTH-1];
  assign empty = (vld_sr_q == '0);

endmodule

// File: rtl/mac16_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac16_dot_sequencer
//   Drives one SB_MAC16 (16x16 signed multiply-accumulate, A/B input regs,
//   pipeline reg2, accumulator output) to compute sum(A[i]*B[i]) for a job of
//   cfg_len operand pairs, returning the 32-bit accumulator on a valid/ready
//   result port.
//   Optional feature: define MAC16_SEQ_OVF_EN to enable the sticky m_ovf flag
//   (OR of MAC16 CO over every accumulate cycle of a job); otherwise m_ovf=0.
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   start, cfg_len,
//   cfg_sub, busy       job command (sampled in IDLE) and busy status
//   s_valid, s_ready,
//   s_a, s_b            signed operand stream
//   m_valid, m_ready,
//   m_data, m_ovf       result port (held until m_ready)
//   mac_*               MAC16 control/data pins, mac_o/mac_co back from MAC16
// -----------------------------------------------------------------------------
module mac16_dot_sequencer
  import mac16_seq_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int ACC_LAT = ACC_LAT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_sub,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [MAC_IW-1:0] s_a,
  input  logic [MAC_IW-1:0] s_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [MAC_OW-1:0] m_data,
  output logic              m_ovf,
  output logic              mac_ce,
  output logic [MAC_IW-1:0] mac_a,
  output logic [MAC_IW-1:0] mac_b,
  output logic              mac_ahold,
  output logic              mac_bhold,
  output logic              mac_irst,
  output logic              mac_orst,
  output logic              mac_ohold,
  output logic              mac_oload,
  output logic              mac_addsub,
  input  logic [MAC_OW-1:0] mac_o,
  input  logic              mac_co
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                sub_q, sub_d;
  logic [MAC_OW-1:0]   m_data_q, m_data_d;
  logic                busy_q, busy_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic                mac_clr_q, mac_clr_d;
  logic                mac_ce_q;
  logic                ovf_clr;
  logic                accept;
  logic                vld_tail;
  logic                vld_empty;

  assign accept = s_valid & s_ready_q;

  mac16_vld_pipe #(.DEPTH(ACC_LAT)) u_vld_pipe (
    .CLK    (CLK),
    .RST    (RST),
    .in_vld (accept),
    .tail   (vld_tail),
    .empty  (vld_empty)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sub_d    = sub_q;
    m_data_d = m_data_q;
    ovf_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sub_d   = cfg_sub;
          ovf_clr = 1'b1;
          if (cfg_len != '0) begin
            rem_d   = cfg_len;
            state_d = FEED;
          end else begin
            m_data_d = '0;
            state_d  = DONE;
          end
        end
      end
      FEED: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Accumulator is final once the last product has left the pipeline.
        if (vld_empty) begin
          m_data_d = mac_o;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register glitch-free
    // and line up with the state they describe.
    busy_d    = (state_d != IDLE);
    s_ready_d = (state_d == FEED);
    m_valid_d = (state_d == DONE);
    mac_clr_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sub_q     <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      mac_clr_q <= 1'b1;
      mac_ce_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sub_q     <= sub_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      mac_clr_q <= mac_clr_d;
      mac_ce_q  <= 1'b1;
    end
  end

`ifdef MAC16_SEQ_OVF_EN
  logic m_ovf_q, m_ovf_d;

  always_comb begin
    m_ovf_d = m_ovf_q;
    if (ovf_clr)
      m_ovf_d = 1'b0;
    else if ((state_q == FEED || state_q == DRAIN) && !mac_ohold)
      m_ovf_d = m_ovf_q | mac_co;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) m_ovf_q <= 1'b0;
    else     m_ovf_q <= m_ovf_d;
  end

  assign m_ovf = m_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{mac_co, ovf_clr};
  assign m_ovf      = 1'b0;
`endif

  assign busy       = busy_q;
  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign mac_ce     = mac_ce_q;
  assign mac_a      = s_a;
  assign mac_b      = s_b;
  // Holding A/B except on accept keeps a stalled operand from re-entering.
  assign mac_ahold  = ~accept;
  assign mac_bhold  = ~accept;
  assign mac_irst   = mac_clr_q;
  assign mac_orst   = mac_clr_q;
  // Accumulate exactly once per accepted pair, when its product arrives.
  assign mac_ohold  = ~vld_tail;
  assign mac_oload  = 1'b0;
  assign mac_addsub = sub_q;

endmodule
